// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage core. Shadows the EX/MEM
// destination info, registers the EX operand-mux selects, and drives IF/ID stall/flush.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              mem_stall_i,
  input  logic              branch_flush_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              bubble_ex_o,
  output logic              flush_id_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_HOLD} state_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } ex_slot_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } mem_slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  state_t     state_q, state_d, held_q, held_d;
  ex_slot_t   ex_q;
  mem_slot_t  mem_q;
  logic [1:0] fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] cnt_q;
  logic       lu_hazard;
  logic       ex_take;

  // The instruction now in EX reaches MEM (01) next cycle; the one in MEM reaches WB (10).
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic used,
                                         input ex_slot_t ex, input mem_slot_t mem);
    logic [1:0] sel;
    sel = SEL_RF;
    if (used && rs != '0) begin
      if (ex.v && ex.regwrite && ex.rd == rs)        sel = SEL_EX;
      else if (mem.v && mem.regwrite && mem.rd == rs) sel = SEL_MEM;
    end
    return sel;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lu_hazard = ex_q.v && ex_q.memread && ex_q.regwrite && (ex_q.rd != '0) &&
                ((id_rs1_used_i && ex_q.rd == id_rs1_i) ||
                 (id_rs2_used_i && ex_q.rd == id_rs2_i));
    ex_take   = id_valid_i && !lu_hazard && !branch_flush_i;

    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    bubble_ex_o = 1'b0;
    flush_id_o  = 1'b0;
    if (mem_stall_i) begin
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
    end else if (branch_flush_i) begin
      flush_id_o  = 1'b1;
      bubble_ex_o = 1'b1;
    end else if (lu_hazard) begin
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      bubble_ex_o = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    if (mem_stall_i) begin
      state_d = MEM_HOLD;
      if (state_q != MEM_HOLD) held_d = state_q;
    end else begin
      unique case (state_q)
        RUN:      if (lu_hazard && !branch_flush_i) state_d = LU_STALL;
        LU_STALL: state_d = RUN;
        MEM_HOLD: state_d = held_q;
        default:  state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      held_q  <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      if (!mem_stall_i) begin
        mem_q <= '{v: ex_q.v, rd: ex_q.rd, regwrite: ex_q.regwrite};
        if (ex_take) begin
          ex_q    <= '{v: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};
          fwd_a_q <= fwd_sel(id_rs1_i, id_rs1_used_i, ex_q, mem_q);
          fwd_b_q <= fwd_sel(id_rs2_i, id_rs2_used_i, ex_q, mem_q);
        end else begin
          ex_q    <= '0;
          fwd_a_q <= SEL_RF;
          fwd_b_q <= SEL_RF;
        end
      end
      if (stall_id_o && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fwd_a_sel_o = fwd_a_q;
  assign fwd_b_sel_o = fwd_b_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: registered selects go through a scoreboard
// queue; combinational stall/flush controls and the stall counter are checked inline.
module tb_hazard_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        mem_stall, branch_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_if, stall_id, bubble_ex, flush_id;
  logic [15:0] stall_cnt;
  logic [3:0]  ctrl;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  assign ctrl = {stall_if, stall_id, bubble_ex, flush_id};

  hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .id_valid_i     (id_valid),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_rs1_used_i  (id_rs1_used),
    .id_rs2_used_i  (id_rs2_used),
    .id_rd_i        (id_rd),
    .id_regwrite_i  (id_regwrite),
    .id_memread_i   (id_memread),
    .mem_stall_i    (mem_stall),
    .branch_flush_i (branch_flush),
    .fwd_a_sel_o    (fwd_a_sel),
    .fwd_b_sel_o    (fwd_b_sel),
    .stall_if_o     (stall_if),
    .stall_id_o     (stall_id),
    .bubble_ex_o    (bubble_ex),
    .flush_id_o     (flush_id),
    .stall_cnt_o    (stall_cnt)
  );

  // Scoreboard consumer: one expected select pair per clock edge that had one pushed.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== {mon_e.a, mon_e.b})
          $display("FAIL %s: fwd_a/fwd_b = %b/%b, expected %b/%b",
                   mon_e.name, fwd_a_sel, fwd_b_sel, mon_e.a, mon_e.b);
        else passes++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] b, input string name);
    exp_t e;
    e.a = a; e.b = b; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      mem_stall = 1'b0; branch_flush = 1'b0;
      #1 push(2'b00, 2'b00, "nop");
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_stall = 1'b0; branch_flush = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    checks++;
    if ({fwd_a_sel, fwd_b_sel, ctrl} !== 8'h00 || stall_cnt !== 16'd0)
      $display("FAIL reset: sels=%b/%b ctrl=%b cnt=%0d, expected 00/00 0000 0", fwd_a_sel, fwd_b_sel, ctrl, stall_cnt);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
    #1 push(2'b00, 2'b00, "b2b_producer");
    @(negedge clk);
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);   // sub x6,x5,x1
    #1;
    checks++;
    if (ctrl !== 4'b0000) $display("FAIL b2b_nostall: ctrl=%b, expected 0000", ctrl);
    else passes++;
    push(2'b01, 2'b00, "b2b_consumer");
    @(negedge clk);
    nops(2);
  endtask

  task automatic test_distance2();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
    #1 push(2'b00, 2'b00, "d2_producer");
    @(negedge clk);
    nops(1);
    set_id(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);   // or x7,x1,x5
    #1 push(2'b00, 2'b10, "d2_mem_fwd");
    @(negedge clk);
    nops(2);
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
    #1 push(2'b00, 2'b00, "prio_first");
    @(negedge clk);
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x3,x4
    #1 push(2'b00, 2'b00, "prio_middle");
    @(negedge clk);
    set_id(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);   // or x7,x1,x5
    #1 push(2'b00, 2'b01, "prio_ex_wins");
    @(negedge clk);
    nops(2);
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);   // lw x8,0(x2)
    #1 push(2'b00, 2'b00, "lu_load");
    @(negedge clk);
    set_id(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x8,x8
    #1;
    checks++;
    if (ctrl !== 4'b1110) $display("FAIL lu_stall: ctrl=%b, expected 1110", ctrl);
    else passes++;
    push(2'b00, 2'b00, "lu_bubble");
    exp_cnt++;
    @(negedge clk);
    #1;
    checks++;
    if (ctrl !== 4'b0000) $display("FAIL lu_one_cycle: ctrl=%b, expected 0000", ctrl);
    else passes++;
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) $display("FAIL lu_cnt: cnt=%0d, expected %0d", stall_cnt, exp_cnt);
    else passes++;
    push(2'b10, 2'b10, "lu_consumer");
    @(negedge clk);
    nops(2);
  endtask

  task automatic test_x0_unused();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);   // addi x0,x1,5
    #1 push(2'b00, 2'b00, "x0_producer");
    @(negedge clk);
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);   // add x1,x0,x0
    #1 push(2'b00, 2'b00, "x0_consumer");
    @(negedge clk);
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);   // lw x3
    #1 push(2'b00, 2'b00, "unused_load");
    @(negedge clk);
    set_id(1'b1, 5'd4, 1'b1, 5'd3, 1'b0, 5'd10, 1'b1, 1'b0);  // rs2=x3 but unused
    #1;
    checks++;
    if (ctrl !== 4'b0000) $display("FAIL unused_nostall: ctrl=%b, expected 0000", ctrl);
    else passes++;
    push(2'b00, 2'b00, "unused_consumer");
    @(negedge clk);
    nops(2);
  endtask

  task automatic test_flush();
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);   // lw x8
    #1 push(2'b00, 2'b00, "fl_load");
    @(negedge clk);
    set_id(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    branch_flush = 1'b1;
    #1;
    checks++;
    if (ctrl !== 4'b0011) $display("FAIL flush_over_lu: ctrl=%b, expected 0011", ctrl);
    else passes++;
    push(2'b00, 2'b00, "fl_squashed");
    @(negedge clk);
    branch_flush = 1'b0;
    set_id(1'b1, 5'd8, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0);  // target: add x10,x8,x1
    #1;
    checks++;
    if (ctrl !== 4'b0000) $display("FAIL fl_target: ctrl=%b, expected 0000", ctrl);
    else passes++;
    push(2'b10, 2'b00, "fl_target_sel");
    @(negedge clk);
    nops(2);
  endtask

  task automatic test_mem_stall();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
    #1 push(2'b00, 2'b00, "ms_first");
    @(negedge clk);
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);   // sub x6,x5,x1
    #1 push(2'b01, 2'b00, "ms_second");
    @(negedge clk);
    set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);   // or x7,x5,x6
    for (int i = 0; i < 3; i++) begin
      mem_stall = 1'b1;
      branch_flush = (i == 1);
      #1;
      checks++;
      if (ctrl !== 4'b1100) $display("FAIL ms_ctrl[%0d]: ctrl=%b, expected 1100", i, ctrl);
      else passes++;
      push(2'b01, 2'b00, "ms_frozen");
      exp_cnt++;
      @(negedge clk);
    end
    mem_stall = 1'b0; branch_flush = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) $display("FAIL ms_cnt: cnt=%0d, expected %0d", stall_cnt, exp_cnt);
    else passes++;
    push(2'b10, 2'b01, "ms_resume");
    @(negedge clk);
    nops(2);
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);   // lw x8
    #1 push(2'b00, 2'b00, "rst_load");
    @(negedge clk);
    set_id(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    checks++;
    if (ctrl !== 4'b1110) $display("FAIL rst_pre_stall: ctrl=%b, expected 1110", ctrl);
    else passes++;
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel, ctrl} !== 8'h00 || stall_cnt !== 16'd0)
      $display("FAIL rst_mid_stall: sels=%b/%b ctrl=%b cnt=%0d, expected 00/00 0000 0", fwd_a_sel, fwd_b_sel, ctrl, stall_cnt);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0);  // add x11,x1,x2
    #1 push(2'b00, 2'b00, "rst_first_instr");
    @(negedge clk);
    nops(2);
  endtask

  task automatic test_saturation();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    mem_stall = 1'b1;
    for (int i = 0; i < 65538; i++) begin
      @(negedge clk);
      if (exp_cnt < 65535) exp_cnt++;
    end
    #1;
    checks++;
    if (stall_cnt !== 16'(exp_cnt) || exp_cnt != 65535)
      $display("FAIL cnt_saturate: cnt=%0d, expected %0d", stall_cnt, 65535);
    else passes++;
    mem_stall = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance2();
    test_load_use();
    test_x0_unused();
    test_flush();
    test_mem_stall();
    test_reset_mid_stall();
    test_saturation();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage core.
- Tracks destination info of instructions in EX and MEM in internal shadow slots.
- Produces the registered 2-bit operand-select codes consumed by the EX-stage 3:1 operand muxes, plus load-use stall, flush and freeze controls for IF/ID.
- Sits in ID, one stage upstream of the EX operand muxes.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk_i  input  1  core clock, rising edge
rst_n_i  input  1  reset, asynchronous, active-low
id_valid_i  input  1  ID holds a valid instruction
id_rs1_i  input  REG_AW  ID source register 1
id_rs2_i  input  REG_AW  ID source register 2
id_rs1_used_i  input  1  instruction reads rs1
id_rs2_used_i  input  1  instruction reads rs2
id_rd_i  input  REG_AW  ID destination register
id_regwrite_i  input  1  ID instruction writes rd
id_memread_i  input  1  ID instruction is a load
mem_stall_i  input  1  data memory busy; freeze the whole pipeline
branch_flush_i  input  1  taken branch/jump resolved in EX
fwd_a_sel_o  output  2  operand A select for EX: 00 regfile, 01 EX/MEM fwd, 10 MEM/WB fwd
fwd_b_sel_o  output  2  operand B select, same encoding
stall_if_o  output  1  hold PC
stall_id_o  output  1  hold IF/ID register
bubble_ex_o  output  1  load NOP into ID/EX
flush_id_o  output  1  clear IF/ID register
stall_cnt_o  output  CNT_W  saturating count of stall cycles (load-use plus mem)

Behaviour:
- Reset (async, rst_n_i low): state RUN; EX and MEM slots invalid; fwd_*_sel_o=00; stall_cnt_o=0. All control outputs are combinational from state and inputs; with slots invalid they evaluate to 0.
- Shadow slots: EX slot {v, rd, regwrite, memread}; MEM slot {v, rd, regwrite}.
- Advance (mem_stall_i=0) updates both slots on the same edge:
  - MEM slot takes the old EX slot.
  - EX slot takes ID info when id_valid_i=1, there is no load-use hazard and branch_flush_i=0; otherwise it becomes invalid (bubble).
- Load-use hazard (combinational):
  - Conditions: EX slot is v & memread & regwrite, rd!=0, and rd matches rs1 with rs1_used or rs2 with rs2_used.
  - Effect: stall_if_o=stall_id_o=bubble_ex_o=1 for exactly one cycle.
  - Next cycle the load sits in MEM, so the consumer gets sel 10.
- Forward select, computed in ID and registered on the advance edge into fwd_*_sel_o:
  - 01 if the EX slot is v & regwrite, rd!=0 and rd==rs.
  - else 10 if the MEM slot is v & regwrite, rd!=0 and rd==rs.
  - else 00.
  - EX priority over MEM. rs unused, rs==x0, bubble or flush register 00. Code 11 is never produced.
  - Register file is write-first; WB-to-ID needs no forwarding.
- branch_flush_i=1 with mem_stall_i=0:
  - flush_id_o=1, bubble_ex_o=1, stall outputs 0.
  - Flush overrides load-use (the wrong-path instruction is discarded).
- mem_stall_i=1:
  - Slots, fwd_*_sel_o and state hold.
  - stall_if_o=stall_id_o=1; bubble_ex_o=0; flush_id_o=0.
  - branch_flush_i is ignored; its source holds it until the freeze ends.
- FSM:
  - RUN -> LU_STALL on a load-use hazard.
  - LU_STALL -> RUN after 1 cycle; the hazard cannot re-fire because the EX slot is now a bubble.
  - any -> MEM_HOLD while mem_stall_i=1; returns to the held state when it drops.
  - Reset mid-stall returns to RUN immediately.
- stall_cnt_o increments on every cycle with stall_id_o=1 and saturates at all-ones.

Test Plan:
- Back-to-back ALU: add x5 then sub x6,x5,x1 -> on the consumer's EX cycle fwd_a_sel_o=01, fwd_b_sel_o=00, no stall.
- Distance-2: add x5, nop, or x7,x1,x5 -> fwd_b_sel_o=10; with x5 also written by the middle instruction -> fwd_b_sel_o=01 (priority).
- Load-use: lw x8 then add x9,x8,x8 -> one cycle stall_if/stall_id/bubble_ex=1, then fwd_a_sel_o=fwd_b_sel_o=10, stall_cnt_o=1.
- x0 and unused rs: addi x0 then add x1,x0,x0 -> sels 00. Load to x3 followed by a consumer with rs2_used=0 and rs2=3 -> no stall.
- Load-use with branch_flush_i=1 the same cycle -> flush_id_o=1, bubble_ex_o=1, stall_if_o=0. mem_stall_i held 3 cycles mid-sequence -> selects and slots frozen, stall_cnt_o +3.
- Reset asserted during LU_STALL -> outputs 0 immediately. After release, the first independent instruction gets sels 00. Counter at 2^CNT_W-1 stays saturated.
